// File: rtl/add_sub_acc_unit_if.sv
// Request/result bundle for add_sub_acc_unit: operands and controls in, registered result and flags out.
// slave = arithmetic unit side, master = requester/consumer side.
interface add_sub_acc_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic             SUB;
    logic             ACC;
    logic             CLR_STICKY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY;
    logic             OVF;
    logic             ZERO;
    logic             NEG;
    logic             OVF_STICKY;
    logic [CNT_W-1:0] OVF_COUNT;

    modport slave (
        input  IN_VALID, OP_A, OP_B, SUB, ACC, CLR_STICKY, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, CARRY, OVF, ZERO, NEG, OVF_STICKY, OVF_COUNT
    );

    modport master (
        output IN_VALID, OP_A, OP_B, SUB, ACC, CLR_STICKY, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, CARRY, OVF, ZERO, NEG, OVF_STICKY, OVF_COUNT
    );
endinterface

// File: rtl/add_sub_acc_unit.sv
// Registered two's-complement add/sub with accumulate, sticky overflow and saturating event count (ADD_SUB_SATURATE_EN clamps on overflow).
// Latency: 1 cycle from accept to OUT_VALID; 1 op/cycle when accept and consume coincide.
// Backpressure: IN_READY = !OUT_VALID | OUT_READY; outputs hold while OUT_VALID & !OUT_READY.
module add_sub_acc_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    add_sub_acc_unit_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] op_a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] res_val;

    assign in_ready = !out_valid_q || bus.OUT_READY;
    assign accept   = bus.IN_VALID && in_ready;

    // Subtraction is A + ~B + 1, so CARRY=1 means no borrow.
    assign op_a_eff = bus.ACC ? acc_q : bus.OP_A;
    assign b_eff    = bus.OP_B ^ {WIDTH{bus.SUB}};
    assign {carry_raw, sum} = {1'b0, op_a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.SUB};
    assign ovf_raw  = (op_a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a_eff[WIDTH-1]);

`ifdef ADD_SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        res_val = sum;
        if (ovf_raw) begin
            res_val = op_a_eff[WIDTH-1] ? MIN_NEG : MAX_POS;
        end
    end
`else
    assign res_val = sum;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_val;
            carry_d     = carry_raw;
            ovf_d       = ovf_raw;
            acc_d       = res_val;
        end else if (out_valid_q && bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end

        // A new overflow event beats a simultaneous clear.
        if (accept && ovf_raw) begin
            sticky_d = 1'b1;
            if (bus.CLR_STICKY) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.CLR_STICKY) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.RESULT     = result_q;
    assign bus.CARRY      = carry_q;
    assign bus.OVF        = ovf_q;
    assign bus.ZERO       = (result_q == '0);
    assign bus.NEG        = result_q[WIDTH-1];
    assign bus.OVF_STICKY = sticky_q;
    assign bus.OVF_COUNT  = cnt_q;

endmodule

// File: tb/tb_add_sub_acc_unit.sv
// Bench for add_sub_acc_unit at WIDTH=4, CNT_W=2 against an integer-arithmetic reference model.
module tb_add_sub_acc_unit;
    localparam int W  = 4;
    localparam int CW = 2;

    logic CLOCK_50;
    logic RESET_N;

    add_sub_acc_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    add_sub_acc_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_valid;
    logic [3:0] m_res;
    bit         m_carry;
    bit         m_ovf;
    bit         m_sticky;
    int         m_cnt;
    logic [3:0] m_acc;

    localparam logic [11:0] RESET_VEC = 12'b0_0000_0_0_1_0_0_00;

    function automatic logic [11:0] dut_vec();
        return {bus.OUT_VALID, bus.RESULT, bus.CARRY, bus.OVF, bus.ZERO, bus.NEG,
                bus.OVF_STICKY, bus.OVF_COUNT};
    endfunction

    function automatic logic [11:0] mdl_vec();
        return {m_valid, m_res, m_carry, m_ovf, (m_res == 4'd0), m_res[3], m_sticky, 2'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_res = '0; m_carry = 0; m_ovf = 0;
        m_sticky = 0; m_cnt = 0; m_acc = '0;
    endtask

    task automatic drive(bit vld, logic [3:0] a, logic [3:0] b, bit sub, bit acc, bit clr, bit ordy);
        bus.IN_VALID   = vld;
        bus.OP_A       = a;
        bus.OP_B       = b;
        bus.SUB        = sub;
        bus.ACC        = acc;
        bus.CLR_STICKY = clr;
        bus.OUT_READY  = ordy;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        bit         take;
        logic [3:0] a;
        int         sa, sb, ua, ub, r;
        bit         n_valid, n_carry, n_ovf, n_sticky;
        logic [3:0] n_res, n_acc;
        int         n_cnt;
        take     = bus.IN_VALID && (!m_valid || bus.OUT_READY);
        n_valid  = take || (m_valid && !bus.OUT_READY);
        n_res    = m_res; n_carry = m_carry; n_ovf = m_ovf; n_acc = m_acc;
        n_sticky = m_sticky; n_cnt = m_cnt;
        if (take) begin
            a  = bus.ACC ? m_acc : bus.OP_A;
            sa = int'($signed(a));
            sb = int'($signed(bus.OP_B));
            ua = a;
            ub = bus.OP_B;
            r  = bus.SUB ? sa - sb : sa + sb;
            n_ovf   = (r > 7) || (r < -8);
            n_carry = bus.SUB ? (ua >= ub) : (ua + ub > 15);
            n_res   = r[3:0];
`ifdef ADD_SUB_SATURATE_EN
            if (n_ovf) n_res = (r > 0) ? 4'b0111 : 4'b1000;
`endif
            n_acc = n_res;
        end
        if (take && n_ovf) begin
            n_sticky = 1;
            n_cnt    = bus.CLR_STICKY ? 1 : ((m_cnt < 3) ? m_cnt + 1 : 3);
        end else if (bus.CLR_STICKY) begin
            n_sticky = 0;
            n_cnt    = 0;
        end
        @(posedge CLOCK_50);
        m_valid = n_valid; m_res = n_res; m_carry = n_carry; m_ovf = n_ovf;
        m_acc = n_acc; m_sticky = n_sticky; m_cnt = n_cnt;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", dut_vec(), RESET_VEC);
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.IN_READY);
        end
    endtask

    task automatic test_overflow_add();
        logic [3:0] exp_res;
`ifdef ADD_SUB_SATURATE_EN
        exp_res = 4'b0111;
`else
        exp_res = 4'b1000;
`endif
        drive(1, 4'b0111, 4'b0001, 0, 0, 0, 1);
        tick();
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        checks++;
        if ({bus.OUT_VALID, bus.RESULT, bus.OVF, bus.CARRY, bus.NEG, bus.OVF_STICKY, bus.OVF_COUNT}
            !== {1'b1, exp_res, 1'b1, 1'b0, exp_res[3], 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL ovf_add: got v=%b r=%b ovf=%b c=%b n=%b st=%b cnt=%0d required r=%b ovf=1 c=0 st=1 cnt=1",
                     bus.OUT_VALID, bus.RESULT, bus.OVF, bus.CARRY, bus.NEG, bus.OVF_STICKY,
                     bus.OVF_COUNT, exp_res);
        end
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL ovf_add_model: got %b required %b", dut_vec(), mdl_vec());
        end
        tick();
    endtask

    task automatic test_subtract();
        drive(1, 4'b0011, 4'b0101, 1, 0, 0, 1);
        tick();
        checks++;
        if ({bus.RESULT, bus.CARRY, bus.OVF, bus.NEG, bus.ZERO} !== {4'b1110, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_neg: got r=%b c=%b ovf=%b n=%b z=%b required r=1110 c=0 ovf=0 n=1 z=0",
                     bus.RESULT, bus.CARRY, bus.OVF, bus.NEG, bus.ZERO);
        end
        drive(1, 4'b0101, 4'b0101, 1, 0, 0, 1);
        tick();
        checks++;
        if ({bus.OUT_VALID, bus.RESULT, bus.CARRY, bus.ZERO} !== {1'b1, 4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got v=%b r=%b c=%b z=%b required v=1 r=0000 c=1 z=1",
                     bus.OUT_VALID, bus.RESULT, bus.CARRY, bus.ZERO);
        end
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got out_valid=%b required 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_backpressure();
        drive(1, 4'd2, 4'd1, 0, 0, 0, 1);
        tick();
        drive(1, 4'd4, 4'd2, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b required 0", bus.IN_READY);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.OUT_VALID, bus.RESULT} !== {1'b1, 4'd3}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%0d required v=1 r=3", i, bus.OUT_VALID, bus.RESULT);
            end
        end
        bus.OUT_READY = 1'b1;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required 1", bus.IN_READY);
        end
        tick();
        checks++;
        if ({bus.OUT_VALID, bus.RESULT} !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL bp_second: got v=%b r=%0d required v=1 r=6", bus.OUT_VALID, bus.RESULT);
        end
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        tick();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: got out_valid=%b required 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_accumulate();
        logic [3:0] exp_seq [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        drive(1, 4'd1, 4'd0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1, 4'd0, 4'd1, 0, 1, 0, 1);
            checks++;
            if ({bus.OUT_VALID, bus.RESULT} !== {1'b1, exp_seq[i]}) begin
                errors++;
                $display("FAIL acc_seq[%0d]: got v=%b r=%b required v=1 r=%b",
                         i, bus.OUT_VALID, bus.RESULT, exp_seq[i]);
            end
        end
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_ovf_counter();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        drive(0, 4'd0, 4'd0, 0, 0, 1, 1);
        tick();
        checks++;
        if ({bus.OVF_STICKY, bus.OVF_COUNT} !== 3'b0_00) begin
            errors++;
            $display("FAIL cnt_preclear: got st=%b cnt=%0d required 0 0", bus.OVF_STICKY, bus.OVF_COUNT);
        end
        drive(1, 4'b0111, 4'b0001, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.OVF_STICKY, bus.OVF_COUNT} !== {1'b1, 2'(exp_cnt[i])}) begin
                errors++;
                $display("FAIL cnt_sat[%0d]: got st=%b cnt=%0d required st=1 cnt=%0d",
                         i, bus.OVF_STICKY, bus.OVF_COUNT, exp_cnt[i]);
            end
        end
        drive(1, 4'b1000, 4'b0001, 1, 0, 1, 1);
        tick();
        checks++;
        if ({bus.OVF, bus.OVF_STICKY, bus.OVF_COUNT} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL cnt_clr_race: got ovf=%b st=%b cnt=%0d required 1 1 1",
                     bus.OVF, bus.OVF_STICKY, bus.OVF_COUNT);
        end
        drive(0, 4'd0, 4'd0, 0, 0, 1, 1);
        tick();
        checks++;
        if ({bus.OVF_STICKY, bus.OVF_COUNT} !== 3'b0_00) begin
            errors++;
            $display("FAIL cnt_clear: got st=%b cnt=%0d required 0 0", bus.OVF_STICKY, bus.OVF_COUNT);
        end
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            #1;
            checks++;
            if (bus.IN_READY !== (!m_valid || bus.OUT_READY)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b required %b", i, bus.IN_READY, (!m_valid || bus.OUT_READY));
            end
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
        end
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 4'b0110, 4'b0101, 0, 0, 0, 1);
        tick();
        drive(0, 4'd0, 4'd0, 0, 0, 0, 0);
        tick();
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL arst_immediate: got %b required %b", dut_vec(), RESET_VEC);
        end
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        drive(0, 4'd0, 4'd0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== RESET_VEC) begin
                errors++;
                $display("FAIL arst_quiet[%0d]: got %b required %b", i, dut_vec(), RESET_VEC);
            end
        end
        drive(1, 4'b0010, 4'b0011, 0, 0, 0, 1);
        tick();
        checks++;
        if ({bus.OUT_VALID, bus.RESULT} !== {1'b1, 4'b0101}) begin
            errors++;
            $display("FAIL arst_new_accept: got v=%b r=%b required v=1 r=0101", bus.OUT_VALID, bus.RESULT);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        drive(0, 4'd0, 4'd0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        test_reset();
        test_overflow_add();
        test_subtract();
        test_backpressure();
        test_accumulate();
        test_ovf_counter();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
